// File: rtl/risc_decode_if.sv
// Decode-stage bundle: instruction and writeback inputs, registered decode results out.
interface risc_decode_if #(
  parameter int DATA_W = 8
);
  logic [12:0]       i_ir;
  logic              i_wbEn;
  logic [2:0]        i_wbAddr;
  logic [DATA_W-1:0] i_wbData;
  logic [3:0]        o_op;
  logic [2:0]        o_rd;
  logic [DATA_W-1:0] o_aData;
  logic [DATA_W-1:0] o_bData;
  logic              o_we;
  logic              o_illegal;
  logic              o_halted;
  logic [7:0]        o_icount;

  modport slave (
    input  i_ir, i_wbEn, i_wbAddr, i_wbData,
    output o_op, o_rd, o_aData, o_bData, o_we, o_illegal, o_halted, o_icount
  );

  modport master (
    output i_ir, i_wbEn, i_wbAddr, i_wbData,
    input  o_op, o_rd, o_aData, o_bData, o_we, o_illegal, o_halted, o_icount
  );
endinterface

// File: rtl/risc_decode.sv
// Decode stage: 8-entry register file with writeback bypass, opcode decode,
// RUN/HALTED control and a saturating issued-instruction counter.
module risc_decode #(
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  risc_decode_if.slave  bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_regFile [8];
  logic [3:0]        r_op;
  logic [2:0]        r_rd;
  logic [DATA_W-1:0] r_aData;
  logic [DATA_W-1:0] r_bData;
  logic              r_we;
  logic              r_illegal;
  logic              r_halted;
  logic [7:0]        r_icount;

  logic [3:0]        w_op;
  logic [2:0]        w_rd;
  logic [2:0]        w_rs;
  logic [2:0]        w_rt;
  logic [5:0]        w_imm;
  logic [DATA_W-1:0] w_rdVal;
  logic [DATA_W-1:0] w_rsVal;
  logic [DATA_W-1:0] w_rtVal;
  logic              w_wbValid;

  assign w_op      = bus.i_ir[12:9];
  assign w_rd      = bus.i_ir[8:6];
  assign w_rs      = bus.i_ir[5:3];
  assign w_rt      = bus.i_ir[2:0];
  assign w_imm     = bus.i_ir[5:0];
  assign w_wbValid = bus.i_wbEn && (bus.i_wbAddr != 3'd0);

  // r0 is hard-wired to zero; a same-cycle writeback to the read index wins over the stored value
  function automatic logic [DATA_W-1:0] readReg(
    input logic [2:0]        idx,
    input logic              wbValid,
    input logic [2:0]        wbAddr,
    input logic [DATA_W-1:0] wbData,
    input logic [DATA_W-1:0] stored
  );
    if (idx == 3'd0)                   return '0;
    else if (wbValid && wbAddr == idx) return wbData;
    else                               return stored;
  endfunction

  assign w_rdVal = readReg(w_rd, w_wbValid, bus.i_wbAddr, bus.i_wbData, r_regFile[w_rd]);
  assign w_rsVal = readReg(w_rs, w_wbValid, bus.i_wbAddr, bus.i_wbData, r_regFile[w_rs]);
  assign w_rtVal = readReg(w_rt, w_wbValid, bus.i_wbAddr, bus.i_wbData, r_regFile[w_rt]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_op      <= 4'd0;
      r_rd      <= 3'd0;
      r_aData   <= '0;
      r_bData   <= '0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
      r_halted  <= 1'b0;
      r_icount  <= 8'd0;
      for (int i = 0; i < 8; i++) r_regFile[i] <= '0;
    end else begin
      // Writeback keeps retiring in-flight results even after HALT
      if (w_wbValid) r_regFile[bus.i_wbAddr] <= bus.i_wbData;

      r_op      <= 4'd0;
      r_rd      <= 3'd0;
      r_aData   <= '0;
      r_bData   <= '0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;

      case (r_state)
        RUN: begin
          case (w_op)
            4'd0: ;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
              r_op <= w_op;
              r_rd <= w_rd;
              r_we <= 1'b1;
              if (r_icount != 8'hFF) r_icount <= r_icount + 8'd1;
              if (w_op == 4'd6) begin
                r_aData <= w_rdVal;
                r_bData <= {{(DATA_W-6){w_imm[5]}}, w_imm};
              end else if (w_op == 4'd7) begin
                r_bData <= {{(DATA_W-6){1'b0}}, w_imm};
              end else begin
                r_aData <= w_rsVal;
                r_bData <= w_rtVal;
              end
            end
            4'd15: begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end
            default: r_illegal <= 1'b1;
          endcase
        end
        HALTED: ;
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.o_op      = r_op;
  assign bus.o_rd      = r_rd;
  assign bus.o_aData   = r_aData;
  assign bus.o_bData   = r_bData;
  assign bus.o_we      = r_we;
  assign bus.o_illegal = r_illegal;
  assign bus.o_halted  = r_halted;
  assign bus.o_icount  = r_icount;

endmodule

// File: tb/tb_risc_decode.sv
// Directed bench for risc_decode: hand-computed vectors for decode, bypass,
// reserved opcodes, HALT behaviour, async reset and icount saturation.
module tb_risc_decode;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   passCount;

  risc_decode_if #(.DATA_W(8)) bus ();

  risc_decode #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drive one cycle of inputs at the falling edge, then settle just after the rising edge
  task automatic applyStimulus(input logic [12:0] ir, input logic wbEn, input logic [2:0] wbAddr, input logic [7:0] wbData);
    @(negedge clk);
    bus.i_ir     = ir;
    bus.i_wbEn   = wbEn;
    bus.i_wbAddr = wbAddr;
    bus.i_wbData = wbData;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.i_ir     = 13'h0000;
    bus.i_wbEn   = 1'b0;
    bus.i_wbAddr = 3'd0;
    bus.i_wbData = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkNopSlot(input string tag);
    checkOutput({tag, " op"}, 32'(bus.o_op), 32'd0);
    checkOutput({tag, " rd"}, 32'(bus.o_rd), 32'd0);
    checkOutput({tag, " a"},  32'(bus.o_aData), 32'd0);
    checkOutput({tag, " b"},  32'(bus.o_bData), 32'd0);
    checkOutput({tag, " we"}, 32'(bus.o_we), 32'd0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n        = 1'b0;
    bus.i_ir     = 13'h0000;
    bus.i_wbEn   = 1'b0;
    bus.i_wbAddr = 3'd0;
    bus.i_wbData = 8'h00;
    #12;
    checkNopSlot("reset");
    checkOutput("reset illegal", 32'(bus.o_illegal), 32'd0);
    checkOutput("reset halted", 32'(bus.o_halted), 32'd0);
    checkOutput("reset icount", 32'(bus.o_icount), 32'd0);

    // LDI r1,#5
    resetDut();
    applyStimulus(13'h0E45, 1'b0, 3'd0, 8'h00);
    checkOutput("ldi op", 32'(bus.o_op), 32'd7);
    checkOutput("ldi rd", 32'(bus.o_rd), 32'd1);
    checkOutput("ldi a", 32'(bus.o_aData), 32'h00);
    checkOutput("ldi b", 32'(bus.o_bData), 32'h05);
    checkOutput("ldi we", 32'(bus.o_we), 32'd1);
    checkOutput("ldi icount", 32'(bus.o_icount), 32'd1);

    // ADD r3,r2,r2 with a same-cycle writeback to r2, then again once it is stored
    resetDut();
    applyStimulus(13'h02D2, 1'b1, 3'd2, 8'h33);
    checkOutput("bypass op", 32'(bus.o_op), 32'd1);
    checkOutput("bypass rd", 32'(bus.o_rd), 32'd3);
    checkOutput("bypass a", 32'(bus.o_aData), 32'h33);
    checkOutput("bypass b", 32'(bus.o_bData), 32'h33);
    checkOutput("bypass we", 32'(bus.o_we), 32'd1);
    applyStimulus(13'h02D2, 1'b0, 3'd0, 8'h00);
    checkOutput("stored a", 32'(bus.o_aData), 32'h33);
    checkOutput("stored icount", 32'(bus.o_icount), 32'd2);

    // SUB r1,r2,r3 with distinct operands: R2=0x21, R3 bypassed as 0x0C
    applyStimulus(13'h0000, 1'b1, 3'd2, 8'h21);
    checkNopSlot("nop");
    checkOutput("nop icount", 32'(bus.o_icount), 32'd2);
    applyStimulus(13'h0453, 1'b1, 3'd3, 8'h0C);
    checkOutput("sub op", 32'(bus.o_op), 32'd2);
    checkOutput("sub a", 32'(bus.o_aData), 32'h21);
    checkOutput("sub b", 32'(bus.o_bData), 32'h0C);

    // ADDI r1,#-1 with R1=0x10
    resetDut();
    applyStimulus(13'h0000, 1'b1, 3'd1, 8'h10);
    applyStimulus(13'h0C7F, 1'b0, 3'd0, 8'h00);
    checkOutput("addi op", 32'(bus.o_op), 32'd6);
    checkOutput("addi a", 32'(bus.o_aData), 32'h10);
    checkOutput("addi b", 32'(bus.o_bData), 32'hFF);
    checkOutput("addi we", 32'(bus.o_we), 32'd1);

    // Writeback to r0 is ignored, both as bypass and as storage (ADD r1,r0,r0)
    applyStimulus(13'h0240, 1'b1, 3'd0, 8'hAA);
    checkOutput("r0 bypass a", 32'(bus.o_aData), 32'h00);
    checkOutput("r0 bypass b", 32'(bus.o_bData), 32'h00);
    applyStimulus(13'h0240, 1'b0, 3'd0, 8'h00);
    checkOutput("r0 stored a", 32'(bus.o_aData), 32'h00);

    // Reserved opcode 8: one-cycle illegal, no count
    resetDut();
    applyStimulus(13'h1000, 1'b0, 3'd0, 8'h00);
    checkNopSlot("illegal");
    checkOutput("illegal flag", 32'(bus.o_illegal), 32'd1);
    checkOutput("illegal icount", 32'(bus.o_icount), 32'd0);
    applyStimulus(13'h0000, 1'b0, 3'd0, 8'h00);
    checkOutput("illegal clears", 32'(bus.o_illegal), 32'd0);
    applyStimulus(13'h1C00, 1'b0, 3'd0, 8'h00);
    checkOutput("illegal op14", 32'(bus.o_illegal), 32'd1);

    // HALT, then everything ignored until reset
    resetDut();
    applyStimulus(13'h0E45, 1'b0, 3'd0, 8'h00);
    applyStimulus(13'h1E00, 1'b0, 3'd0, 8'h00);
    checkNopSlot("halt");
    checkOutput("halt halted", 32'(bus.o_halted), 32'd1);
    checkOutput("halt icount", 32'(bus.o_icount), 32'd1);
    applyStimulus(13'h02D2, 1'b1, 3'd2, 8'h33);
    checkNopSlot("halted add");
    checkOutput("halted still", 32'(bus.o_halted), 32'd1);
    checkOutput("halted icount", 32'(bus.o_icount), 32'd1);
    applyStimulus(13'h1000, 1'b0, 3'd0, 8'h00);
    checkOutput("halted illegal", 32'(bus.o_illegal), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async halted", 32'(bus.o_halted), 32'd0);
    checkOutput("async icount", 32'(bus.o_icount), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(13'h0E45, 1'b0, 3'd0, 8'h00);
    checkOutput("resume op", 32'(bus.o_op), 32'd7);
    checkOutput("resume icount", 32'(bus.o_icount), 32'd1);

    // 300 ADDs: count reaches 0xFF and holds
    resetDut();
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(13'h02D2, 1'b0, 3'd0, 8'h00);
      if (i == 254) checkOutput("icount 254", 32'(bus.o_icount), 32'hFE);
      if (i == 255) checkOutput("icount 255", 32'(bus.o_icount), 32'hFF);
    end
    checkOutput("icount sat", 32'(bus.o_icount), 32'hFF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
